// File: rtl/controlador_relogio.sv
// Turn/time controller for a two-player chess clock. It sequences the game
// and emits tick, clear and increment pulses to the white and black counters.
module controlador_relogio #(
  parameter int TICK_DIV = 4,
  parameter int PW       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       pausa,
  input  logic       fim_b,
  input  logic       fim_p,
  output logic       zera_s,
  output logic       conta_b,
  output logic       conta_p,
  output logic       decresce_b,
  output logic       decresce_p,
  output logic       vez,
  output logic       pausado,
  output logic       fim_jogo,
  output logic       perdedor,
  output logic [2:0] estado_db
);

  localparam logic [2:0] INICIAL  = 3'd0;
  localparam logic [2:0] ZERA     = 3'd1;
  localparam logic [2:0] VEZ_B    = 3'd2;
  localparam logic [2:0] VEZ_P    = 3'd3;
  localparam logic [2:0] APLICA_B = 3'd4;
  localparam logic [2:0] APLICA_P = 3'd5;
  localparam logic [2:0] PAUSA    = 3'd6;
  localparam logic [2:0] FIM      = 3'd7;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [2:0]    estado_q, estado_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          vez_q, vez_d;
  logic          perdedor_q, perdedor_d;

  logic          em_vez;
  logic          fim_vez;
  logic          tick;

  // Only the timeout flag of the side on turn matters; the other is ignored.
  always_comb begin
    em_vez  = (estado_q == VEZ_B) || (estado_q == VEZ_P);
    fim_vez = (estado_q == VEZ_P) ? fim_p : fim_b;
    tick    = em_vez && (presc_q == PRESC_MAX) && !fim_vez && !pausa && !jogada;
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    estado_d   = estado_q;
    presc_d    = presc_q;
    vez_d      = vez_q;
    perdedor_d = perdedor_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = ZERA;
      end
      ZERA: begin
        presc_d  = '0;
        vez_d    = 1'b0;
        estado_d = VEZ_B;
      end
      VEZ_B, VEZ_P: begin
        if (fim_vez) begin
          estado_d   = FIM;
          perdedor_d = (estado_q == VEZ_P);
        end else if (pausa) begin
          estado_d = PAUSA;
        end else if (jogada) begin
          // A tick coinciding with the move is dropped; the new turn starts fresh.
          presc_d  = '0;
          estado_d = (estado_q == VEZ_B) ? APLICA_B : APLICA_P;
        end else begin
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end
      end
      APLICA_B: begin
        vez_d    = 1'b1;
        estado_d = VEZ_P;
      end
      APLICA_P: begin
        vez_d    = 1'b0;
        estado_d = VEZ_B;
      end
      PAUSA: begin
        if (iniciar)     estado_d = ZERA;
        else if (!pausa) estado_d = vez_q ? VEZ_P : VEZ_B;
      end
      FIM: begin
        if (iniciar) estado_d = ZERA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= INICIAL;
      presc_q    <= '0;
      vez_q      <= 1'b0;
      perdedor_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      presc_q    <= presc_d;
      vez_q      <= vez_d;
      perdedor_q <= perdedor_d;
    end
  end

  // Outputs are forced low while reset is asserted, whatever state is held.
  // During ZERA/APLICA the turn output already shows the side about to play.
  always_comb begin
    zera_s     = 1'b0;
    conta_b    = 1'b0;
    conta_p    = 1'b0;
    decresce_b = 1'b0;
    decresce_p = 1'b0;
    vez        = 1'b0;
    pausado    = 1'b0;
    fim_jogo   = 1'b0;
    perdedor   = 1'b0;
    estado_db  = INICIAL;
    if (!reset) begin
      zera_s     = (estado_q == ZERA);
      conta_b    = tick && (estado_q == VEZ_B);
      conta_p    = tick && (estado_q == VEZ_P);
      decresce_b = (estado_q == APLICA_B);
      decresce_p = (estado_q == APLICA_P);
      pausado    = (estado_q == PAUSA);
      fim_jogo   = (estado_q == FIM);
      perdedor   = perdedor_q;
      estado_db  = estado_q;
      case (estado_q)
        ZERA:     vez = 1'b0;
        APLICA_B: vez = 1'b1;
        APLICA_P: vez = 1'b0;
        default:  vez = vez_q;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_relogio.sv
// Self-checking bench for controlador_relogio: directed game scenarios followed
// by random play, all compared against a turn/phase reference model.
module tb_controlador_relogio;

  localparam int TD = 4;
  localparam int PW = 3;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, pausa, fim_b, fim_p;
  logic       zera_s, conta_b, conta_p, decresce_b, decresce_p;
  logic       vez, pausado, fim_jogo, perdedor;
  logic [2:0] estado_db;

  controlador_relogio #(.TICK_DIV(TD), .PW(PW)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .pausa     (pausa),
    .fim_b     (fim_b),
    .fim_p     (fim_p),
    .zera_s    (zera_s),
    .conta_b   (conta_b),
    .conta_p   (conta_p),
    .decresce_b(decresce_b),
    .decresce_p(decresce_p),
    .vez       (vez),
    .pausado   (pausado),
    .fim_jogo  (fim_jogo),
    .perdedor  (perdedor),
    .estado_db (estado_db)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: game mode, side on turn, cycles elapsed in the current tick window.
  typedef enum int {M_IDLE, M_CLEAR, M_TURN, M_APPLY, M_PAUSED, M_OVER} mode_t;
  mode_t m_mode  = M_IDLE;
  bit    m_side  = 1'b0;
  bit    m_loser = 1'b0;
  int    m_phase = 0;

  logic       o_zera, o_cb, o_cp, o_db, o_dp, o_vez, o_pau, o_fim, o_perd;
  logic [2:0] o_est;

  function automatic logic [2:0] model_code();
    case (m_mode)
      M_IDLE:   return 3'd0;
      M_CLEAR:  return 3'd1;
      M_TURN:   return m_side ? 3'd3 : 3'd2;
      M_APPLY:  return m_side ? 3'd5 : 3'd4;
      M_PAUSED: return 3'd6;
      default:  return 3'd7;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare every output, then advance the model.
  task automatic step(input bit ini, input bit jog, input bit pau,
                      input bit fb, input bit fp, input bit rst);
    bit e_cb, e_cp, e_vez, my_fim;
    iniciar = ini; jogada = jog; pausa = pau; fim_b = fb; fim_p = fp; reset = rst;
    #1;
    my_fim = m_side ? fp : fb;
    e_cb   = !rst && m_mode == M_TURN && !m_side && m_phase == TD - 1 && !my_fim && !pau && !jog;
    e_cp   = !rst && m_mode == M_TURN &&  m_side && m_phase == TD - 1 && !my_fim && !pau && !jog;
    e_vez  = rst ? 1'b0 : (m_mode == M_CLEAR) ? 1'b0 : (m_mode == M_APPLY) ? !m_side : m_side;
    o_zera = zera_s; o_cb = conta_b; o_cp = conta_p; o_db = decresce_b; o_dp = decresce_p;
    o_vez = vez; o_pau = pausado; o_fim = fim_jogo; o_perd = perdedor; o_est = estado_db;
    check("zera_s",     o_zera, !rst && m_mode == M_CLEAR);
    check("conta_b",    o_cb,   e_cb);
    check("conta_p",    o_cp,   e_cp);
    check("decresce_b", o_db,   !rst && m_mode == M_APPLY && !m_side);
    check("decresce_p", o_dp,   !rst && m_mode == M_APPLY &&  m_side);
    check("vez",        o_vez,  e_vez);
    check("pausado",    o_pau,  !rst && m_mode == M_PAUSED);
    check("fim_jogo",   o_fim,  !rst && m_mode == M_OVER);
    check("perdedor",   o_perd, !rst && m_loser);
    check("estado_db",  o_est,  rst ? 3'd0 : model_code());
    check("conta_excl", o_cb & o_cp, 1'b0);
    @(posedge clock);
    if (rst) begin
      m_mode = M_IDLE; m_side = 1'b0; m_loser = 1'b0; m_phase = 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (ini) m_mode = M_CLEAR;
        M_CLEAR: begin m_side = 1'b0; m_phase = 0; m_mode = M_TURN; end
        M_TURN: begin
          if (my_fim)   begin m_mode = M_OVER; m_loser = m_side; end
          else if (pau) m_mode = M_PAUSED;
          else if (jog) begin m_mode = M_APPLY; m_phase = 0; end
          else          m_phase = (m_phase + 1) % TD;
        end
        M_APPLY:  begin m_side = !m_side; m_mode = M_TURN; end
        M_PAUSED: if (ini) m_mode = M_CLEAR; else if (!pau) m_mode = M_TURN;
        default:  if (ini) m_mode = M_CLEAR;
      endcase
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit pau_lvl;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; pausa = 1'b0; fim_b = 1'b0; fim_p = 1'b0;
    @(negedge clock);

    // Reset and idle.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("reset_estado", o_est, 3'd0);
    step(1, 0, 0, 0, 0, 0);

    // Start: single ZERA cycle, then white ticks every 4th cycle.
    step(0, 0, 0, 0, 0, 0);
    check("start_zera", o_zera, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (i == 1) check("start_zera_one_cycle", o_zera, 1'b0);
      check("start_conta_b", o_cb, (i % 4) == 0);
      check("start_conta_p", o_cp, 1'b0);
    end

    // Move on the tick cycle: tick dropped, increment applied, black starts.
    idle(3);
    step(0, 1, 0, 0, 0, 0);
    check("move_no_tick", o_cb, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    check("move_decresce_b", o_db, 1'b1);
    check("move_vez", o_vez, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("move_conta_p", o_cp, i == 4);
    end

    // Pause at prescaler 2 for 10 cycles, then resume from the held phase.
    idle(2);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, 0, 0, 0);
      check("pause_no_tick", o_cp, 1'b0);
      if (i > 1) check("pause_pausado", o_pau, 1'b1);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("resume_first", o_cp, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    check("resume_tick", o_cp, 1'b1);

    // Back to white, then timeout checks.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("apply_p", o_dp, 1'b1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("fim_p_ignored", o_est, 3'd2);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("timeout_fim_jogo", o_fim, 1'b1);
    check("timeout_perdedor", o_perd, 1'b0);
    check("timeout_no_decresce", o_db, 1'b0);
    step(0, 1, 1, 0, 0, 0);
    check("fim_hold", o_est, 3'd7);

    // Restart from FIM, then black loses on timeout.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("restart_zera", o_zera, 1'b1);
    step(0, 1, 0, 0, 0, 0);
    check("restart_vez", o_vez, 1'b0);
    check("restart_estado", o_est, 3'd2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    check("black_loses", o_perd, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    check("perdedor_holds_in_zera", o_perd, 1'b1);

    // Reset during APLICA_P.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("reset_aplica_dp", o_dp, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    check("after_reset_estado", o_est, 3'd0);
    check("after_reset_perdedor", o_perd, 1'b0);

    // Random play.
    pau_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 6) pau_lvl = !pau_lvl;
      step($urandom_range(99) < 4, $urandom_range(99) < 20, pau_lvl,
           $urandom_range(99) < 3, $urandom_range(99) < 3, $urandom_range(99) < 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_relogio.md
CONTROLADOR_RELOGIO -- requirements
Module: controlador_relogio

Interface
REQ-001 Parameter: TICK_DIV, default 4, clock cycles per time unit (tick); legal range >= 2.
REQ-002 Parameter: PW, default 3, prescaler width; 2^PW >= TICK_DIV.
REQ-003 Port: clock  in  1  system clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: iniciar  in  1  start/restart request, sampled each cycle.
REQ-006 Port: jogada  in  1  move-completed pulse from the player on turn.
REQ-007 Port: pausa  in  1  level; while 1 the game is held.
REQ-008 Port: fim_b, fim_p  in  1 each  timeout flags from the white and black counters.
REQ-009 Port: zera_s  out  1  clear to both counters.
REQ-010 Port: conta_b, conta_p  out  1 each  one-tick count enables to the white and black counters.
REQ-011 Port: decresce_b, decresce_p  out  1 each  increment-apply pulses to the white and black counters.
REQ-012 Port: vez  out  1  player on turn: 0 = white, 1 = black.
REQ-013 Port: pausado, fim_jogo, perdedor  out  1 each  pause indicator, game-over indicator, and losing side (0 = white, 1 = black).
REQ-014 Port: estado_db  out  3  encoded FSM state, for debug.

Function
REQ-015 FSM states and encodings: INICIAL=0, ZERA=1, VEZ_B=2, VEZ_P=3, APLICA_B=4, APLICA_P=5, PAUSA=6, FIM=7.
REQ-016 INICIAL: transition to ZERA on iniciar=1; otherwise hold.
REQ-017 ZERA: lasts exactly 1 cycle with zera_s=1; clears the prescaler and vez; next state VEZ_B.
REQ-018 VEZ_x: transitions have the priority fim_x > pausa > jogada > tick.
  - fim_x=1: go to FIM; perdedor <= x.
  - pausa=1: go to PAUSA; prescaler holds its value.
  - jogada=1: go to APLICA_x; prescaler <= 0; any coincident tick is discarded.
  - Otherwise: prescaler increments, wrapping from TICK_DIV-1 to 0.
REQ-019 Tick: conta_x = 1 combinationally in VEZ_x when prescaler = TICK_DIV-1, fim_x=0, pausa=0 and jogada=0; otherwise 0.
REQ-020 conta_b and conta_p are never 1 in the same cycle.
REQ-021 The fim flag of the player not on turn is ignored.
REQ-022 APLICA_x: lasts exactly 1 cycle with decresce_x=1; toggles vez; next state VEZ_other.
REQ-023 APLICA_x: jogada, pausa and iniciar are ignored during this cycle.
REQ-024 PAUSA: pausado=1; no conta or decresce pulses; jogada and fim_* are ignored.
REQ-025 PAUSA: iniciar=1 goes to ZERA (priority); else pausa=0 returns to VEZ_B when vez=0 or VEZ_P when vez=1, resuming from the held prescaler value.
REQ-026 FIM: fim_jogo=1; perdedor holds; all counter controls are 0; iniciar=1 goes to ZERA.
REQ-027 iniciar in VEZ_x has no effect.
REQ-028 vez changes only in APLICA_x and ZERA.
REQ-029 perdedor changes only on entry to FIM and on reset.
REQ-030 Outputs zera_s, decresce_*, pausado, fim_jogo and estado_db are Moore decodes of the state; conta_* is Mealy per REQ-019.
REQ-031 Prescaler arithmetic is unsigned modulo TICK_DIV; no value >= TICK_DIV is ever reached.

Reset
REQ-032 reset=1 at a clock edge forces state INICIAL, prescaler 0, vez 0, perdedor 0.
REQ-033 While in reset, all outputs are 0 except estado_db=0.
REQ-034 reset overrides every other input in every state, including mid-ZERA, APLICA_x and PAUSA.

Verification (TICK_DIV=4)
REQ-035 Start: reset, then iniciar pulse -> zera_s=1 for exactly 1 cycle, then VEZ_B; conta_b pulses every 4th cycle, first pulse 4 cycles after entering VEZ_B; conta_p stays 0.
REQ-036 Move: jogada on the cycle prescaler=3 in VEZ_B -> no conta_b that cycle; next cycle decresce_b=1 and vez=1; conta_p first pulses 4 cycles after entering VEZ_P.
REQ-037 Pause: pausa raised at prescaler=2 in VEZ_P and held 10 cycles -> no pulses, pausado=1; after release, conta_p fires 2 cycles after re-entering VEZ_P (prescaler reaches 3 after one increment).
REQ-038 Timeout: fim_p=1 in VEZ_B -> ignored; fim_b=1 together with jogada in VEZ_B -> FIM, perdedor=0, fim_jogo=1, no decresce_b pulse.
REQ-039 Restart/reset: iniciar in FIM -> ZERA, then VEZ_B with vez=0; reset asserted during APLICA_P -> INICIAL next cycle, decresce_p=0, all outputs 0.
